lsu_load_store_unit: RTL and testbench
======================================

Name: lsu_load_store_unit

Overview:
- Multi-cycle load/store unit between the datapath and data memory.
- Takes the ALU-computed effective address, store data and funct3.
- Runs a request/grant/valid handshake with data memory and stalls the core while the access is outstanding.
- Returns aligned, sign- or zero-extended load data; `load_data` is the memory-data input of the writeback 4:1 select.

Parameters:
- TIMEOUT, 16, max cycles spent in WAIT before the access aborts with err (1..255).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begin an access (sampled in IDLE only)
- is_load  in  1  access is a load
- is_store  in  1  access is a store (is_load has priority if both high)
- funct3  in  3  RV32 width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte effective address
- wdata  in  32  store data (rs2)
- stall  out  1  hold PC/pipeline
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; misaligned, illegal funct3 or timeout
- load_data  out  32  extended load result to writeback select
- mem_req  out  1  request to data memory
- mem_we  out  1  write enable
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  store data lane-shifted
- mem_wstrb  out  4  byte enables
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Behaviour:
- Reset values: state=IDLE; stall, done, err, mem_req, mem_we = 0; mem_addr, mem_wdata, mem_wstrb, load_data = 0; timeout counter = 0.
- A synchronous rst in any state returns to IDLE next edge and drops mem_req; an in-flight response is discarded.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - start with neither is_load nor is_store -> ignored, stay IDLE.
  - start with a valid access: latch addr, funct3, type and wdata.
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0) or illegal funct3 (loads: 011/110/111; stores: anything but 000/001/010) -> go to DONE with err_pending=1; no memory access.
  - Otherwise -> go to REQ.
- stall is combinational: 1 in IDLE when start has a valid type, 1 in REQ and WAIT, 0 in DONE. So a single-cycle core freezes in the start cycle.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_wstrb, mem_wdata are stable.
  - On mem_gnt: store -> DONE; load -> WAIT with counter cleared.
  - No timeout applies in REQ.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: capture the extracted data into load_data, then go to DONE.
  - Otherwise the counter increments; when it reaches TIMEOUT-1 without rvalid -> DONE with err=1, load_data=0.
  - An rvalid arriving in the same cycle as the limit wins; the access completes normally.
- DONE:
  - done=1 and err valid for exactly one cycle, then IDLE.
  - start is ignored in DONE; back-to-back accesses therefore cost at least one idle cycle.
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011 << addr[1:0] (addr[1] only); wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111; wdata unchanged.
- Load extract:
  - Byte select = mem_rdata >> (8*addr[1:0]); halfword select = mem_rdata >> (16*addr[1]).
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- load_data holds its value until the next successful load or until err (cleared to 0). Stores do not change it.
- mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.

Test Plan:
- LW at 0x100, mem_gnt 1 cycle after req, rvalid 2 cycles later with rdata=0xDEADBEEF -> load_data=0xDEADBEEF; done pulse with err=0; stall high from start until the DONE cycle.
- LB at 0x103, rdata=0x80FF_0000 -> load_data=0xFFFF_FF80; LBU at the same address -> 0x0000_0080; LHU at 0x102 -> 0x0000_80FF.
- SB at 0x201 with wdata=0x1234_56AB -> mem_addr=0x200, wstrb=0010, mem_wdata=0xABAB_ABAB, mem_we=1; done 1 cycle after gnt.
- LW at 0x102 or SH at 0x1 -> no mem_req ever asserted; done and err=1 in the cycle after start; load_data=0.
- TIMEOUT=4, load granted but rvalid never arrives -> done and err=1 after 4 WAIT cycles; a late rvalid arriving afterwards is ignored.
- rst asserted in WAIT -> next cycle IDLE with all outputs at reset values; a following LW at 0x0 with rdata=5 completes normally with load_data=5.

Source files
------------

// File: rtl/lsu_load_store_unit.sv
// Multi-cycle RV32 load/store unit: req/gnt/rvalid handshake to data memory,
// store lane steering, load extraction and extension, access timeout.
module lsu_load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [7:0] LIMIT  = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_load;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_err;
    logic [7:0]  r_cnt;
    logic [31:0] r_load_data;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;

    logic        w_valid;
    logic        w_f3_ok;
    logic        w_misal;
    logic        w_bad;
    logic [31:0] w_lane_data;
    logic [3:0]  w_lane_strb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_valid = is_load | is_store;

    always_comb begin
        w_f3_ok = 1'b0;
        if (is_load) begin
            w_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                      (funct3 == 3'b010) || (funct3 == 3'b100) ||
                      (funct3 == 3'b101);
        end else begin
            w_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                      (funct3 == 3'b010);
        end
    end

    assign w_misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign w_bad   = !w_f3_ok || w_misal;

    // Loads never drive byte enables; only stores steer lanes.
    always_comb begin
        w_lane_data = wdata;
        w_lane_strb = 4'b0000;
        if (!is_load) begin
            case (funct3[1:0])
                2'b00: begin
                    w_lane_strb = 4'b0001 << addr[1:0];
                    w_lane_data = {4{wdata[7:0]}};
                end
                2'b01: begin
                    w_lane_strb = 4'b0011 << {addr[1], 1'b0};
                    w_lane_data = {2{wdata[15:0]}};
                end
                default: begin
                    w_lane_strb = 4'b1111;
                    w_lane_data = wdata;
                end
            endcase
        end
    end

    always_comb begin
        case (r_off)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
    end

    assign w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'b0, w_byte};
            3'b101:  w_ext = {16'b0, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_load      <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_err       <= 1'b0;
            r_cnt       <= 8'd0;
            r_load_data <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_valid) begin
                        r_load      <= is_load;
                        r_funct3    <= funct3;
                        r_off       <= addr[1:0];
                        r_mem_addr  <= {addr[31:2], 2'b00};
                        r_mem_wdata <= w_lane_data;
                        r_mem_wstrb <= w_lane_strb;
                        if (w_bad) begin
                            r_err       <= 1'b1;
                            r_load_data <= 32'd0;
                            r_state     <= S_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_cnt   <= 8'd0;
                        r_state <= r_load ? S_WAIT : S_DONE;
                    end
                end
                S_WAIT: begin
                    // A response on the limit cycle still completes normally.
                    if (mem_rvalid) begin
                        r_load_data <= w_ext;
                        r_state     <= S_DONE;
                    end else if (r_cnt == LIMIT) begin
                        r_err       <= 1'b1;
                        r_load_data <= 32'd0;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall     = (r_state == S_IDLE) ? (start && w_valid) :
                       ((r_state == S_REQ) || (r_state == S_WAIT));
    assign done      = (r_state == S_DONE);
    assign err       = done && r_err;
    assign mem_req   = (r_state == S_REQ);
    assign mem_we    = mem_req && !r_load;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign load_data = r_load_data;

endmodule

// File: tb/tb_lsu_load_store_unit.sv
// Directed bench for lsu_load_store_unit (TIMEOUT=4) with a scripted
// memory responder and hand-computed expectations.
module tb_lsu_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall, done, err, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    lsu_load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .err(err),
        .load_data(load_data),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Result of one access as seen by the scripted responder.
    int          lat;
    logic        sreq, st0, stall_ok, e_o, qwe;
    logic [31:0] ldo, qa, qd;
    logic [3:0]  qs;

    // gd: req cycles before gnt; rd: wait cycles before rvalid (-1 = never)
    task automatic access(input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gd,
                          input int rd, input logic [31:0] rdat);
        int   rq;
        int   wc;
        logic granted;
        logic got;
        rq = 0; wc = 0; granted = 0; got = 0;
        lat = -1; sreq = 0; stall_ok = 1; e_o = 0; ldo = 0;
        qa = 0; qd = 0; qs = 0; qwe = 0;
        @(negedge clk);
        start = 1; is_load = ld; is_store = st;
        funct3 = f3; addr = a; wdata = wd;
        #1 st0 = stall;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            start = 0; is_load = 0; is_store = 0;
            mem_gnt = 0; mem_rvalid = 0;
            #1;
            if (done) begin
                got = 1; lat = c; e_o = err; ldo = load_data;
                if (stall !== 1'b0) stall_ok = 0;
            end else begin
                if (stall !== 1'b1) stall_ok = 0;
                if (mem_req) begin
                    if (!sreq) begin
                        qa = mem_addr; qd = mem_wdata;
                        qs = mem_wstrb; qwe = mem_we;
                    end
                    sreq = 1;
                    if (rq == gd) begin
                        mem_gnt = 1; granted = 1;
                    end
                    rq++;
                end else if (granted) begin
                    if (wc == rd) begin
                        mem_rvalid = 1; mem_rdata = rdat;
                    end
                    wc++;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({stall, done, err, mem_req, mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {stall, done, err, mem_req, mem_we});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_wstrb, load_data} !== 100'd0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected 0",
                     mem_addr, mem_wdata, mem_wstrb, load_data);
        end
        rst = 0;
    endtask

    task automatic test_lw;
        access(1, 0, 3'b010, 32'h100, 0, 1, 1, 32'hDEADBEEF);
        checks++;
        if (ldo !== 32'hDEADBEEF || e_o !== 1'b0) begin
            errors++;
            $display("FAIL lw_data: got %h err=%b expected deadbeef err=0",
                     ldo, e_o);
        end
        checks++;
        if (lat !== 4 || qa !== 32'h100 || qwe !== 1'b0) begin
            errors++;
            $display("FAIL lw_timing: got lat=%0d addr=%h we=%b expected 4/100/0",
                     lat, qa, qwe);
        end
        checks++;
        if (st0 !== 1'b1 || stall_ok !== 1'b1) begin
            errors++;
            $display("FAIL lw_stall: got start=%b ok=%b expected 1/1",
                     st0, stall_ok);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL lw_done_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_extend;
        access(1, 0, 3'b000, 32'h103, 0, 0, 0, 32'h80FF0000);
        checks++;
        if (ldo !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL lb: got %h expected ffffff80", ldo);
        end
        access(1, 0, 3'b100, 32'h103, 0, 0, 0, 32'h80FF0000);
        checks++;
        if (ldo !== 32'h00000080) begin
            errors++;
            $display("FAIL lbu: got %h expected 00000080", ldo);
        end
        access(1, 0, 3'b101, 32'h102, 0, 0, 0, 32'h80FF0000);
        checks++;
        if (ldo !== 32'h000080FF) begin
            errors++;
            $display("FAIL lhu: got %h expected 000080ff", ldo);
        end
        access(1, 0, 3'b001, 32'h102, 0, 0, 1, 32'h80FF0000);
        checks++;
        if (ldo !== 32'hFFFF80FF) begin
            errors++;
            $display("FAIL lh: got %h expected ffff80ff", ldo);
        end
        access(1, 0, 3'b000, 32'h101, 0, 0, 0, 32'h00007F00);
        checks++;
        if (ldo !== 32'h0000007F) begin
            errors++;
            $display("FAIL lb_pos: got %h expected 0000007f", ldo);
        end
    endtask

    task automatic test_store;
        access(0, 1, 3'b000, 32'h201, 32'h123456AB, 0, -1, 0);
        checks++;
        if (qa !== 32'h200 || qs !== 4'b0010 || qwe !== 1'b1) begin
            errors++;
            $display("FAIL sb_ctrl: got %h/%b/%b expected 200/0010/1",
                     qa, qs, qwe);
        end
        checks++;
        if (qd !== 32'hABABABAB || lat !== 1 || e_o !== 1'b0) begin
            errors++;
            $display("FAIL sb_data: got %h lat=%0d err=%b expected abababab/1/0",
                     qd, lat, e_o);
        end
        checks++;
        if (ldo !== 32'h0000007F) begin
            errors++;
            $display("FAIL sb_keeps_load: got %h expected 0000007f", ldo);
        end
        access(0, 1, 3'b001, 32'h202, 32'h0000BEEF, 2, -1, 0);
        checks++;
        if (qs !== 4'b1100 || qd !== 32'hBEEFBEEF || lat !== 3) begin
            errors++;
            $display("FAIL sh: got %b/%h lat=%0d expected 1100/beefbeef/3",
                     qs, qd, lat);
        end
        access(0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 0, -1, 0);
        checks++;
        if (qs !== 4'b1111 || qd !== 32'hCAFEF00D || qa !== 32'h300) begin
            errors++;
            $display("FAIL sw: got %b/%h/%h expected 1111/cafef00d/300",
                     qs, qd, qa);
        end
    endtask

    task automatic test_misaligned;
        access(1, 0, 3'b010, 32'h102, 0, 0, 0, 32'h11111111);
        checks++;
        if (sreq !== 1'b0 || lat !== 0 || e_o !== 1'b1 || ldo !== 0) begin
            errors++;
            $display("FAIL lw_misal: got req=%b lat=%0d err=%b ld=%h expected 0/0/1/0",
                     sreq, lat, e_o, ldo);
        end
        access(0, 1, 3'b001, 32'h1, 32'hFFFF, 0, -1, 0);
        checks++;
        if (sreq !== 1'b0 || lat !== 0 || e_o !== 1'b1) begin
            errors++;
            $display("FAIL sh_misal: got req=%b lat=%0d err=%b expected 0/0/1",
                     sreq, lat, e_o);
        end
        access(1, 0, 3'b011, 32'h0, 0, 0, 0, 0);
        checks++;
        if (sreq !== 1'b0 || e_o !== 1'b1) begin
            errors++;
            $display("FAIL ld_illegal: got req=%b err=%b expected 0/1", sreq, e_o);
        end
        access(0, 1, 3'b100, 32'h0, 0, 0, -1, 0);
        checks++;
        if (sreq !== 1'b0 || e_o !== 1'b1) begin
            errors++;
            $display("FAIL st_illegal: got req=%b err=%b expected 0/1", sreq, e_o);
        end
    endtask

    task automatic test_ignored_start;
        @(negedge clk);
        start = 1; is_load = 0; is_store = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL no_type_stall: got %b expected 0", stall);
        end
        @(negedge clk);
        start = 0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL no_type_idle: got req=%b done=%b expected 0/0",
                     mem_req, done);
        end
    endtask

    task automatic test_timeout;
        access(1, 0, 3'b010, 32'h40, 0, 0, 3, 32'h00C0FFEE);
        checks++;
        if (lat !== 5 || e_o !== 1'b0 || ldo !== 32'h00C0FFEE) begin
            errors++;
            $display("FAIL rvalid_at_limit: got lat=%0d err=%b ld=%h expected 5/0/00c0ffee",
                     lat, e_o, ldo);
        end
        access(1, 0, 3'b010, 32'h40, 0, 0, -1, 0);
        checks++;
        if (lat !== 5 || e_o !== 1'b1 || ldo !== 0) begin
            errors++;
            $display("FAIL timeout: got lat=%0d err=%b ld=%h expected 5/1/0",
                     lat, e_o, ldo);
        end
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_rvalid = 0;
        #1;
        checks++;
        if (load_data !== 0 || done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL late_rvalid: got ld=%h done=%b stall=%b expected 0/0/0",
                     load_data, done, stall);
        end
    endtask

    task automatic test_reset_in_wait;
        access(1, 0, 3'b010, 32'h80, 0, 0, 0, 32'h77);
        @(negedge clk);
        start = 1; is_load = 1; funct3 = 3'b010; addr = 32'h204;
        @(negedge clk);
        start = 0; is_load = 0;
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL in_wait: got req=%b stall=%b expected 0/1",
                     mem_req, stall);
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        mem_rvalid = 1; mem_rdata = 32'h99;
        #1;
        checks++;
        if ({stall, done, err, mem_req, mem_we} !== 5'b0 ||
            {mem_addr, mem_wdata, mem_wstrb, load_data} !== 100'd0) begin
            errors++;
            $display("FAIL rst_wait: got %b %h/%h/%h/%h expected all 0",
                     {stall, done, err, mem_req, mem_we},
                     mem_addr, mem_wdata, mem_wstrb, load_data);
        end
        @(negedge clk);
        mem_rvalid = 0;
        #1;
        checks++;
        if (load_data !== 0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard: got ld=%h done=%b expected 0/0",
                     load_data, done);
        end
        access(1, 0, 3'b010, 32'h0, 0, 0, 0, 32'd5);
        checks++;
        if (ldo !== 32'd5 || e_o !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL after_rst: got ld=%h err=%b lat=%0d expected 5/0/2",
                     ldo, e_o, lat);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_extend();
        test_store();
        test_misaligned();
        test_ignored_start();
        test_timeout();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
